fx1_issue_arb: RTL

Shared-FX1 arbiter and sequencer. Two issue requesters (slot 0, slot 1) compete for one 128-bit simple-fixed datapath covering halfword/word add, subtract-from and logical ops. The block arbitrates round-robin, runs accepted ops through a fixed 2-stage pipeline with writeback backpressure, and supports flush. It sits between the issue/dependency logic and the register-file writeback port.

---
 rtl/fx1_issue_arb_if.sv | 44 ++++
 rtl/fx1_issue_arb.sv | 110 +++++++++++
 2 files changed

// File: rtl/fx1_issue_arb_if.sv
// Issue-side and writeback-side signal bundle for the shared FX1 arbiter.
// The master drives the requests and res_ready; the slave (the arbiter) drives the results.
interface fx1_issue_arb_if #(
    parameter int unsigned RT_W = 7
);
    logic            req0_valid;
    logic            req0_ready;
    logic [2:0]      req0_op;
    logic [0:127]    req0_ra;
    logic [0:127]    req0_rb;
    logic [RT_W-1:0] req0_rt;

    logic            req1_valid;
    logic            req1_ready;
    logic [2:0]      req1_op;
    logic [0:127]    req1_ra;
    logic [0:127]    req1_rb;
    logic [RT_W-1:0] req1_rt;

    logic            flush;
    logic            res_valid;
    logic            res_ready;
    logic [0:127]    res_data;
    logic [RT_W-1:0] res_rt;
    logic            res_src;
    logic            res_err;
    logic            busy;

    modport master (
        output req0_valid, req0_op, req0_ra, req0_rb, req0_rt,
        output req1_valid, req1_op, req1_ra, req1_rb, req1_rt,
        output flush, res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_rt, res_src, res_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_ra, req0_rb, req0_rt,
        input  req1_valid, req1_op, req1_ra, req1_rb, req1_rt,
        input  flush, res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_rt, res_src, res_err, busy
    );
endinterface

// File: rtl/fx1_issue_arb.sv
// Round-robin arbiter for two issue slots sharing one 128-bit simple-fixed datapath,
// with a 2-stage pipeline, writeback backpressure and flush.
module fx1_issue_arb #(
    parameter int unsigned RT_W = 7,
    parameter int unsigned LAT  = 2
) (
    input logic           clk,
    input logic           reset,
    fx1_issue_arb_if.slave bus
);
    if (LAT != 2) begin : g_lat_check
        $error("fx1_issue_arb supports only LAT == 2");
    end

    logic            s1_valid;
    logic [2:0]      s1_op;
    logic [0:127]    s1_ra;
    logic [0:127]    s1_rb;
    logic [RT_W-1:0] s1_rt;
    logic            s1_src;

    logic            s2_valid;
    logic [0:127]    s2_data;
    logic [RT_W-1:0] s2_rt;
    logic            s2_src;
    logic            s2_err;

    logic            last_grant;
    logic            stall;
    logic            can_issue;
    logic            sel1;
    logic            accept;
    logic [0:127]    alu_data;
    logic            alu_err;

    assign stall     = s2_valid & ~bus.res_ready;
    assign can_issue = ~stall & ~bus.flush & ~reset;

    // On contention the slot that did not win last time gets the grant.
    assign sel1 = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;

    assign bus.req0_ready = bus.req0_valid & ~sel1 & can_issue;
    assign bus.req1_ready = bus.req1_valid &  sel1 & can_issue;
    assign accept         = bus.req0_ready | bus.req1_ready;

    // Each lane uses its own slice, keeping carries and borrows inside the lane.
    always_comb begin
        alu_data = '0;
        alu_err  = 1'b0;
        case (s1_op)
            3'b000: for (int k = 0; k < 8; k++)
                alu_data[16*k +: 16] = s1_ra[16*k +: 16] + s1_rb[16*k +: 16];
            3'b001: for (int k = 0; k < 4; k++)
                alu_data[32*k +: 32] = s1_ra[32*k +: 32] + s1_rb[32*k +: 32];
            3'b010: for (int k = 0; k < 8; k++)
                alu_data[16*k +: 16] = s1_rb[16*k +: 16] - s1_ra[16*k +: 16];
            3'b011: for (int k = 0; k < 4; k++)
                alu_data[32*k +: 32] = s1_rb[32*k +: 32] - s1_ra[32*k +: 32];
            3'b100:  alu_data = s1_ra & s1_rb;
            3'b101:  alu_data = s1_ra | s1_rb;
            3'b110:  alu_data = s1_ra ^ s1_rb;
            default: alu_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_ra      <= '0;
            s1_rb      <= '0;
            s1_rt      <= '0;
            s1_src     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_rt      <= '0;
            s2_src     <= 1'b0;
            s2_err     <= 1'b0;
            last_grant <= 1'b1;
        end else if (bus.flush) begin
            // Payload registers are left alone so res_* stay stable while invalid.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                last_grant <= sel1;
                s1_op      <= sel1 ? bus.req1_op : bus.req0_op;
                s1_ra      <= sel1 ? bus.req1_ra : bus.req0_ra;
                s1_rb      <= sel1 ? bus.req1_rb : bus.req0_rb;
                s1_rt      <= sel1 ? bus.req1_rt : bus.req0_rt;
                s1_src     <= sel1;
            end
            if (s1_valid) begin
                s2_data <= alu_data;
                s2_rt   <= s1_rt;
                s2_src  <= s1_src;
                s2_err  <= alu_err;
            end
        end
    end

    assign bus.res_valid = s2_valid;
    assign bus.res_data  = s2_data;
    assign bus.res_rt    = s2_rt;
    assign bus.res_src   = s2_src;
    assign bus.res_err   = s2_err;
    assign bus.busy      = s1_valid | s2_valid;
endmodule
